// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: debounced add/dec/mode keys with auto-repeat driving a clamped,
// triangular-sweeping DDS frequency word.
module freq_sweep_ctrl #(
    parameter int DEB_CYCLES = 20,
    parameter int REP_DELAY  = 500,
    parameter int REP_PERIOD = 100,
    parameter int DWELL      = 1000,
    parameter int STEP       = 4,
    parameter int INIT_WORD  = 8,
    parameter int MIN_WORD   = 4,
    parameter int MAX_WORD   = 4092
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_add,
    input  logic        key_dec,
    input  logic        key_mode,
    output logic [11:0] freq_word,
    output logic        sweeping,
    output logic        word_upd
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int RW = $clog2((REP_DELAY > REP_PERIOD ? REP_DELAY : REP_PERIOD) + 1);
    localparam int WW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {MANUAL, SWEEP_UP, SWEEP_DOWN} state_t;
    state_t state, state_nxt;

    logic [2:0]    raw, s1, s2, deb, deb_d, press;
    logic [DW-1:0] bcnt [3];
    logic [1:0]    held, fire, rpt;
    logic [RW-1:0] rcnt [2];
    logic [WW-1:0] dcnt;
    logic [12:0]   up, dn;
    logic [11:0]   up_c, dn_c, word_nxt;
    logic          inc, dec, tc;

    assign raw      = {key_mode, key_dec, key_add};
    assign press    = deb_d & ~deb;
    assign sweeping = state != MANUAL;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            s1    <= '1;
            s2    <= '1;
            deb   <= '1;
            deb_d <= '1;
            for (int i = 0; i < 3; i++) bcnt[i] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_d <= deb;
            for (int i = 0; i < 3; i++)
                if (s2[i] == deb[i]) bcnt[i] <= '0;
                else if (bcnt[i] == DW'(DEB_CYCLES - 1)) begin
                    bcnt[i] <= '0;
                    deb[i]  <= s2[i];
                end else bcnt[i] <= bcnt[i] + 1'b1;
        end

    // Repeat timing only runs while exactly one of add/dec is held in MANUAL
    assign held = {~deb[1] & deb[0], ~deb[0] & deb[1]} & {2{state == MANUAL}};

    always_comb
        for (int i = 0; i < 2; i++)
            fire[i] = held[i] && rcnt[i] == (rpt[i] ? RW'(REP_PERIOD) : RW'(REP_DELAY));

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rpt <= '0;
            for (int i = 0; i < 2; i++) rcnt[i] <= '0;
        end else
            for (int i = 0; i < 2; i++)
                if (!held[i]) begin
                    rcnt[i] <= '0;
                    rpt[i]  <= 1'b0;
                end else if (fire[i]) begin
                    rcnt[i] <= RW'(1);
                    rpt[i]  <= 1'b1;
                end else rcnt[i] <= rcnt[i] + 1'b1;

    assign inc  = state == MANUAL && deb[1] && (press[0] || fire[0]);
    assign dec  = state == MANUAL && deb[0] && (press[1] || fire[1]);
    assign up   = {1'b0, freq_word} + 13'(STEP);
    assign dn   = {1'b0, freq_word} - 13'(STEP);
    assign up_c = up > 13'(MAX_WORD) ? 12'(MAX_WORD) : up[11:0];
    assign dn_c = (dn[12] || dn[11:0] < 12'(MIN_WORD)) ? 12'(MIN_WORD) : dn[11:0];
    assign tc   = dcnt == WW'(DWELL - 1);

    always_comb begin
        state_nxt = state;
        word_nxt  = freq_word;
        if (press[2]) state_nxt = state == MANUAL ? SWEEP_UP : MANUAL;
        else if (state == MANUAL) word_nxt = inc ? up_c : dec ? dn_c : freq_word;
        else if (tc && state == SWEEP_UP) begin
            word_nxt  = up_c;
            state_nxt = up_c == 12'(MAX_WORD) ? SWEEP_DOWN : SWEEP_UP;
        end else if (tc) begin
            word_nxt  = dn_c;
            state_nxt = dn_c == 12'(MIN_WORD) ? SWEEP_UP : SWEEP_DOWN;
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= MANUAL;
            freq_word <= 12'(INIT_WORD);
            word_upd  <= 1'b0;
            dcnt      <= '0;
        end else begin
            state     <= state_nxt;
            freq_word <= word_nxt;
            word_upd  <= word_nxt != freq_word;
            dcnt      <= (state == MANUAL || state_nxt != state || tc) ? '0 : dcnt + 1'b1;
        end
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// tb_freq_sweep_ctrl: directed key sequences; expected freq_word updates go through a scoreboard queue.
module tb_freq_sweep_ctrl;
    logic        clk = 1'b0, reset = 1'b0;
    logic        key_add = 1'b1, key_dec = 1'b1, key_mode = 1'b1;
    logic [11:0] freq_word;
    logic        sweeping, word_upd;
    int          tests = 0, fails = 0;
    int          cyc = 0, last_cyc = 0;
    logic        last_sw = 1'b0;
    logic [11:0] exp_q [$];
    logic [11:0] exp_w;

    freq_sweep_ctrl #(
        .DEB_CYCLES(4), .REP_DELAY(10), .REP_PERIOD(3), .DWELL(5)
    ) dut (
        .clk(clk), .reset(reset), .key_add(key_add), .key_dec(key_dec), .key_mode(key_mode),
        .freq_word(freq_word), .sweeping(sweeping), .word_upd(word_upd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (reset && word_upd) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL upd_unexpected: freq_word=%0d, expected no update", freq_word);
            end else begin
                exp_w = exp_q.pop_front();
                if (freq_word != exp_w) begin
                    fails++;
                    $display("FAIL upd_word: got %0d, expected %0d", freq_word, exp_w);
                end
            end
            if (sweeping && last_sw) begin
                tests++;
                if (cyc - last_cyc != 5) begin
                    fails++;
                    $display("FAIL sweep_gap: got %0d cycles, expected 5", cyc - last_cyc);
                end
            end
            last_sw  = sweeping;
            last_cyc = cyc;
        end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 60000 cycles, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [2:0] m, input int n);
        {key_mode, key_dec, key_add} = ~m;
        tick(n);
        {key_mode, key_dec, key_add} = 3'b111;
    endtask

    task automatic push_ramp(input int from, input int to);
        for (int v = from; v <= to; v += 4) exp_q.push_back(12'(v));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
    endtask

    initial begin
        tick(3);
        check("rst_word", freq_word, 8);
        check("rst_sweeping", sweeping, 0);
        check("rst_upd", word_upd, 0);
        reset = 1'b1;
        tick(2);

        // single short press; step lands 2+4+1 cycles after the raw edge
        exp_q.push_back(12);
        key_add = 1'b0;
        tick(6);
        check("latency_early", freq_word, 8);
        tick(1);
        check("latency_step", freq_word, 12);
        tick(3);
        key_add = 1'b1;
        tick(15);
        check("single_word", freq_word, 12);
        check("single_sweeping", sweeping, 0);
        check("single_q", exp_q.size(), 0);

        reset = 1'b0;
        #1;
        check("async_rst_word", freq_word, 8);
        tick(2);
        reset = 1'b1;
        tick(2);

        exp_q.push_back(4);
        for (int i = 0; i < 3; i++) begin
            key_dec = 1'b0;
            tick(2);
            key_dec = 1'b1;
            tick(2);
        end
        hold(3'b010, 6);
        tick(15);
        check("bounce_word", freq_word, 4);
        hold(3'b010, 6);
        tick(15);
        check("clamp_min_word", freq_word, 4);
        check("bounce_q", exp_q.size(), 0);

        // 30-cycle hold: press step at 12, repeats at +10 then every 3 -> 8 steps to 40
        pulse_reset();
        push_ramp(12, 40);
        hold(3'b001, 30);
        tick(15);
        check("repeat_word", freq_word, 40);
        check("repeat_q", exp_q.size(), 0);

        hold(3'b011, 30);
        tick(15);
        check("both_word", freq_word, 40);

        // 3063-cycle hold yields 1019 steps: 8 -> 4084
        pulse_reset();
        push_ramp(12, 4084);
        hold(3'b001, 3063);
        tick(15);
        check("preload_word", freq_word, 4084);
        check("preload_q", exp_q.size(), 0);

        exp_q.push_back(4088);
        exp_q.push_back(4092);
        exp_q.push_back(4088);
        exp_q.push_back(4084);
        hold(3'b100, 6);
        check("pre_sweep", sweeping, 0);
        tick(7);
        check("sweeping_on", sweeping, 1);
        hold(3'b001, 6);
        tick(6);
        hold(3'b100, 6);
        check("sweep_down_word", freq_word, 4084);
        tick(10);
        check("sweep_exit", sweeping, 0);
        check("mode_wins_word", freq_word, 4084);
        check("sweep_q", exp_q.size(), 0);

        // 72-cycle hold yields 22 steps to 96, then one sweep step to 100
        pulse_reset();
        push_ramp(12, 100);
        hold(3'b001, 72);
        tick(15);
        check("pre_sweep2_word", freq_word, 96);
        hold(3'b100, 6);
        tick(6);
        check("mid_sweep_word", freq_word, 100);
        check("mid_sweep_upd", word_upd, 1);
        #5;
        reset = 1'b0;
        #1;
        check("rst_mid_word", freq_word, 8);
        check("rst_mid_sweeping", sweeping, 0);
        check("rst_mid_upd", word_upd, 0);
        tick(2);
        reset = 1'b1;
        tick(20);
        check("post_rst_word", freq_word, 8);
        check("post_rst_sweeping", sweeping, 0);
        check("final_q", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
